// File: rtl/hwpe_tcdm_to_axi_pkg.sv
// Shared HWPE control-path types: 32-bit TCDM request/response and single-beat AXI4 channels.
package hwpe_tcdm_to_axi_pkg;

  localparam int unsigned CtrlAddrWidth = 32;
  localparam int unsigned CtrlDataWidth = 32;
  localparam int unsigned CtrlStrbWidth = CtrlDataWidth / 8;
  localparam int unsigned CtrlIdWidth   = 2;
  localparam int unsigned CtrlUserWidth = 4;
  localparam int unsigned AmoWidth      = 4;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] RespOkay  = 2'b00;

  typedef logic [CtrlAddrWidth-1:0] addr_t;
  typedef logic [CtrlDataWidth-1:0] data_t;
  typedef logic [CtrlStrbWidth-1:0] strb_t;
  typedef logic [CtrlIdWidth-1:0]   id_t;
  typedef logic [CtrlUserWidth-1:0] user_t;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  typedef struct packed {
    addr_t                addr;
    logic                 write;
    data_t                data;
    strb_t                strb;
    logic [AmoWidth-1:0]  amo;
    user_t                user;
  } tcdm_req_chan_t;

  typedef struct packed {
    data_t data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } axi_aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } axi_w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } axi_b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } axi_ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } axi_r_chan_t;

  typedef struct packed {
    logic         aw_valid;
    axi_aw_chan_t aw;
    logic         w_valid;
    axi_w_chan_t  w;
    logic         b_ready;
    logic         ar_valid;
    axi_ar_chan_t ar;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  function automatic logic [2:0] axi_size(int unsigned data_width);
    return (data_width == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/hwpe_tcdm_to_axi.sv
// TCDM master to single-beat AXI4 master bridge; responses return in request order because
// the request stream drains completely before switching between reads and writes.
module hwpe_tcdm_to_axi
  import hwpe_tcdm_to_axi_pkg::*;
#(
  parameter int unsigned      AddrWidth      = 32,
  parameter int unsigned      DataWidth      = 32,
  parameter int unsigned      IdWidth        = 2,
  parameter logic [IdWidth-1:0] AxiId        = '0,
  parameter int unsigned      MaxOutstanding = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  tcdm_req_t tcdm_req_i,
  output tcdm_rsp_t tcdm_rsp_o,
  output axi_req_t  axi_req_o,
  input  axi_rsp_t  axi_rsp_i,
  output logic      err_o
);

  localparam int unsigned         CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);
  localparam logic [2:0]          AxiSize  = axi_size(DataWidth);

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   pend_write_q, pend_write_d;
  logic                   aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  data_t                  data_q, data_d;
  strb_t                  strb_q, strb_d;
  user_t                  user_q, user_d;
  logic                   p_valid_q, p_valid_d;
  data_t                  p_data_q, p_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic q_ready, accept, rsp_hs;
  logic unused_rsp;

  // Only one direction is ever in flight, so B and R never collide.
  assign q_ready = !rst_i && (state_q == IDLE) && (cnt_q < CntMax) &&
                   ((cnt_q == '0) || (tcdm_req_i.q.write == pend_write_q));
  assign accept  = tcdm_req_i.q_valid && q_ready;
  assign rsp_hs  = axi_rsp_i.b_valid || axi_rsp_i.r_valid;

  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id,
                        axi_rsp_i.r.last, axi_rsp_i.r.user};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d   = tcdm_req_i.q.write ? WR : RD;
        aw_pend_d = tcdm_req_i.q.write;
        w_pend_d  = tcdm_req_i.q.write;
      end
      RD: if (axi_rsp_i.ar_ready) state_d = IDLE;
      WR: begin
        aw_pend_d = aw_pend_q && !axi_rsp_i.aw_ready;
        w_pend_d  = w_pend_q && !axi_rsp_i.w_ready;
        if (!aw_pend_d && !w_pend_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_req_o            = '0;
    axi_req_o.aw_valid   = (state_q == WR) && aw_pend_q;
    axi_req_o.aw.id      = AxiId;
    axi_req_o.aw.addr    = addr_q;
    axi_req_o.aw.size    = AxiSize;
    axi_req_o.aw.burst   = BurstIncr;
    axi_req_o.aw.user    = user_q;
    axi_req_o.w_valid    = (state_q == WR) && w_pend_q;
    axi_req_o.w.data     = data_q;
    axi_req_o.w.strb     = strb_q;
    axi_req_o.w.last     = 1'b1;
    axi_req_o.w.user     = user_q;
    axi_req_o.ar_valid   = (state_q == RD);
    axi_req_o.ar.id      = AxiId;
    axi_req_o.ar.addr    = addr_q;
    axi_req_o.ar.size    = AxiSize;
    axi_req_o.ar.burst   = BurstIncr;
    axi_req_o.ar.user    = user_q;
    axi_req_o.b_ready    = 1'b1;
    axi_req_o.r_ready    = 1'b1;
    tcdm_rsp_o           = '0;
    tcdm_rsp_o.q_ready   = q_ready;
    tcdm_rsp_o.p_valid   = p_valid_q;
    tcdm_rsp_o.p.data    = p_data_q;
    err_o = rsp_err_q || (accept && (tcdm_req_i.q.amo != '0));
  end

  // Request latch, outstanding counter and the single response register.
  always_comb begin
    cnt_d        = cnt_q;
    pend_write_d = pend_write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    user_d       = user_q;
    if (accept) begin
      pend_write_d = tcdm_req_i.q.write;
      addr_d       = tcdm_req_i.q.addr;
      data_d       = tcdm_req_i.q.data;
      strb_d       = tcdm_req_i.q.strb;
      user_d       = tcdm_req_i.q.user;
    end
    if (accept && !rsp_hs)      cnt_d = cnt_q + CntWidth'(1);
    else if (!accept && rsp_hs) cnt_d = cnt_q - CntWidth'(1);
    p_valid_d = rsp_hs;
    p_data_d  = axi_rsp_i.r_valid ? axi_rsp_i.r.data : '0;
    rsp_err_d = (axi_rsp_i.b_valid && (axi_rsp_i.b.resp != RespOkay)) ||
                (axi_rsp_i.r_valid && (axi_rsp_i.r.resp != RespOkay));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      pend_write_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      user_q       <= '0;
      p_valid_q    <= 1'b0;
      p_data_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_write_q <= pend_write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      user_q       <= user_d;
      p_valid_q    <= p_valid_d;
      p_data_q     <= p_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_hwpe_tcdm_to_axi.sv
// Directed bench for hwpe_tcdm_to_axi: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_hwpe_tcdm_to_axi;
  import hwpe_tcdm_to_axi_pkg::*;

  logic      clk_i, rst_i, err_o;
  tcdm_req_t req;
  tcdm_rsp_t rsp;
  axi_req_t  axi_req;
  axi_rsp_t  axi_rsp;
  int        n_cmp, n_bad;

  hwpe_tcdm_to_axi #(.MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tcdm_req_i(req), .tcdm_rsp_o(rsp),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    @(negedge clk_i); req.q_valid = 1'b1; #1;
    n_cmp++; if (rsp.q_ready !== 1'b0) begin n_bad++; $display("FAIL rst_q_ready got %b want 0", rsp.q_ready); end
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid} !== 3'b000) begin n_bad++;
      $display("FAIL rst_axi_valid got %b want 000", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}); end
    n_cmp++; if ({rsp.p_valid, err_o} !== 2'b00 || rsp.p.data !== 32'h0) begin n_bad++;
      $display("FAIL rst_p got pv=%b err=%b data=%h want 0/0/0", rsp.p_valid, err_o, rsp.p.data); end
    @(negedge clk_i); rst_i = 1'b0; req.q_valid = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h1000; req.q.amo = '0;
    axi_rsp.ar_ready = 1'b1; #1;
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_bad++; $display("FAIL rd_q_ready got %b want 1", rsp.q_ready); end
    @(negedge clk_i); req.q_valid = 1'b0; #1;
    n_cmp++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.addr !== 32'h1000) begin n_bad++;
      $display("FAIL rd_ar got v=%b a=%h want 1/00001000", axi_req.ar_valid, axi_req.ar.addr); end
    n_cmp++; if ({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst} !== {8'd0, 3'd2, 2'b01}) begin n_bad++;
      $display("FAIL rd_ar_fields got len=%0d size=%0d burst=%0d want 0/2/1", axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst); end
    @(negedge clk_i); #1;
    n_cmp++; if (axi_req.ar_valid !== 1'b0) begin n_bad++; $display("FAIL rd_ar_drop got %b want 0", axi_req.ar_valid); end
    @(negedge clk_i); axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 32'hDEADBEEF; axi_rsp.r.resp = 2'b00;
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'hDEADBEEF || err_o !== 1'b0) begin n_bad++;
      $display("FAIL rd_p got pv=%b data=%h err=%b want 1/deadbeef/0", rsp.p_valid, rsp.p.data, err_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (rsp.p_valid !== 1'b0) begin n_bad++; $display("FAIL rd_p_drop got %b want 0", rsp.p_valid); end
  endtask

  task automatic test_write_aw_delay();
    @(negedge clk_i);
    req.q_valid = 1'b1; req.q.write = 1'b1; req.q.addr = 32'h2000; req.q.data = 32'hCAFEF00D;
    req.q.strb = 4'hF; req.q.user = 4'h5; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b1;
    @(negedge clk_i); req.q_valid = 1'b0; #1;
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b11) begin n_bad++;
      $display("FAIL wr_first got aw=%b w=%b want 1/1", axi_req.aw_valid, axi_req.w_valid); end
    n_cmp++; if (axi_req.w.data !== 32'hCAFEF00D || axi_req.w.strb !== 4'hF || axi_req.w.last !== 1'b1 || axi_req.aw.user !== 4'h5) begin n_bad++;
      $display("FAIL wr_payload got d=%h s=%h l=%b u=%h want cafef00d/f/1/5", axi_req.w.data, axi_req.w.strb, axi_req.w.last, axi_req.aw.user); end
    @(negedge clk_i); #1;
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b10) begin n_bad++;
      $display("FAIL wr_w_drop got aw=%b w=%b want 1/0", axi_req.aw_valid, axi_req.w_valid); end
    @(negedge clk_i); axi_rsp.aw_ready = 1'b1; #1;
    n_cmp++; if (axi_req.aw_valid !== 1'b1 || axi_req.aw.addr !== 32'h2000 || rsp.q_ready !== 1'b0) begin n_bad++;
      $display("FAIL wr_aw_hold got aw=%b a=%h qr=%b want 1/00002000/0", axi_req.aw_valid, axi_req.aw.addr, rsp.q_ready); end
    @(negedge clk_i); axi_rsp.aw_ready = 1'b0; #1;
    n_cmp++; if (axi_req.aw_valid !== 1'b0 || rsp.q_ready !== 1'b1) begin n_bad++;
      $display("FAIL wr_idle got aw=%b qr=%b want 0/1", axi_req.aw_valid, rsp.q_ready); end
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
    @(negedge clk_i); axi_rsp.b_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'h0) begin n_bad++;
      $display("FAIL wr_b got pv=%b data=%h want 1/0", rsp.p_valid, rsp.p.data); end
  endtask

  task automatic test_outstanding();
    int acc = 0;
    int pv = 0;
    axi_rsp.ar_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i); req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h3000 + 32'(4 * i); #1;
      if (rsp.q_ready === 1'b1) acc++;
    end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL max_out accepts got %0d want 4", acc); end
    n_cmp++; if (rsp.q_ready !== 1'b0) begin n_bad++; $display("FAIL max_out_block got %b want 0", rsp.q_ready); end
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 32'h1;
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; #1;
    n_cmp++; if (rsp.q_ready !== 1'b1 || rsp.p_valid !== 1'b1) begin n_bad++;
      $display("FAIL max_out_reopen got qr=%b pv=%b want 1/1", rsp.q_ready, rsp.p_valid); end
    @(negedge clk_i); req.q_valid = 1'b0; #1;
    n_cmp++; if (axi_req.ar_valid !== 1'b1 || rsp.q_ready !== 1'b0) begin n_bad++;
      $display("FAIL max_out_fifth got ar=%b qr=%b want 1/0", axi_req.ar_valid, rsp.q_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); axi_rsp.r_valid = (i < 4); #1;
      if (rsp.p_valid === 1'b1) pv++;
    end
    n_cmp++; if (pv !== 4) begin n_bad++; $display("FAIL max_out_drain got %0d want 4", pv); end
    req.q.write = 1'b1; #1;
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_bad++; $display("FAIL max_out_empty got %b want 1", rsp.q_ready); end
  endtask

  task automatic test_back_to_back_order();
    int early = 0;
    axi_rsp.ar_ready = 1'b1; axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    @(negedge clk_i); req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h4000;
    @(negedge clk_i); req.q.write = 1'b1; req.q.data = 32'h1111; req.q.strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); axi_rsp.r_valid = (i == 4); axi_rsp.r.data = 32'hAAAA; #1;
      if (rsp.q_ready !== 1'b0) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL order_wr_blocked got %0d early readies want 0", early); end
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'hAAAA || rsp.q_ready !== 1'b1) begin n_bad++;
      $display("FAIL order_r1 got pv=%b d=%h qr=%b want 1/0000aaaa/1", rsp.p_valid, rsp.p.data, rsp.q_ready); end
    @(negedge clk_i); req.q.write = 1'b0; req.q.addr = 32'h4004; #1;
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b11 || axi_req.w.data !== 32'h1111 || rsp.q_ready !== 1'b0) begin n_bad++;
      $display("FAIL order_wr got aw=%b w=%b d=%h qr=%b want 1/1/00001111/0", axi_req.aw_valid, axi_req.w_valid, axi_req.w.data, rsp.q_ready); end
    @(negedge clk_i); #1;
    n_cmp++; if (rsp.q_ready !== 1'b0) begin n_bad++; $display("FAIL order_rd_blocked got %b want 0", rsp.q_ready); end
    axi_rsp.b_valid = 1'b1;
    @(negedge clk_i); axi_rsp.b_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'h0 || rsp.q_ready !== 1'b1) begin n_bad++;
      $display("FAIL order_b got pv=%b d=%h qr=%b want 1/0/1", rsp.p_valid, rsp.p.data, rsp.q_ready); end
    @(negedge clk_i); req.q_valid = 1'b0; #1;
    n_cmp++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.addr !== 32'h4004) begin n_bad++;
      $display("FAIL order_ar2 got v=%b a=%h want 1/00004004", axi_req.ar_valid, axi_req.ar.addr); end
    @(negedge clk_i); axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 32'hBBBB;
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'hBBBB) begin n_bad++;
      $display("FAIL order_r2 got pv=%b d=%h want 1/0000bbbb", rsp.p_valid, rsp.p.data); end
  endtask

  task automatic test_errors();
    @(negedge clk_i); req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h5000; req.q.amo = '0;
    @(negedge clk_i); req.q_valid = 1'b0;
    @(negedge clk_i); axi_rsp.r_valid = 1'b1; axi_rsp.r.resp = 2'b10; axi_rsp.r.data = 32'h5555; #1;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL slverr_early got %b want 0", err_o); end
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; axi_rsp.r.resp = 2'b00; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'h5555 || err_o !== 1'b1) begin n_bad++;
      $display("FAIL slverr got pv=%b d=%h err=%b want 1/00005555/1", rsp.p_valid, rsp.p.data, err_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL slverr_pulse got %b want 0", err_o); end
    req.q_valid = 1'b1; req.q.write = 1'b1; req.q.amo = 4'h1; req.q.data = 32'h77; req.q.strb = 4'h3; #1;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL amo_err got %b want 1", err_o); end
    @(negedge clk_i); req.q_valid = 1'b0; req.q.amo = '0; #1;
    n_cmp++; if (err_o !== 1'b0 || {axi_req.aw_valid, axi_req.w_valid} !== 2'b11 || axi_req.w.data !== 32'h77 ||
                 axi_req.w.strb !== 4'h3 || axi_req.aw.atop !== 6'h0) begin n_bad++;
      $display("FAIL amo_plain got err=%b aw=%b w=%b d=%h s=%h atop=%h want 0/1/1/00000077/3/0",
               err_o, axi_req.aw_valid, axi_req.w_valid, axi_req.w.data, axi_req.w.strb, axi_req.aw.atop); end
    @(negedge clk_i); axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
    @(negedge clk_i); axi_rsp.b_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || err_o !== 1'b0) begin n_bad++;
      $display("FAIL amo_b got pv=%b err=%b want 1/0", rsp.p_valid, err_o); end
  endtask

  task automatic test_reset_mid();
    axi_rsp.ar_ready = 1'b1;
    @(negedge clk_i); req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h6000;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_cmp++; if ({rsp.q_ready, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, rsp.p_valid, err_o} !== 6'b0) begin n_bad++;
      $display("FAIL mid_rst got qr=%b ar=%b aw=%b w=%b pv=%b err=%b want all 0",
               rsp.q_ready, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, rsp.p_valid, err_o); end
    @(negedge clk_i); rst_i = 1'b0; req.q_valid = 1'b0; req.q.write = 1'b1; #1;
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_cnt got qr=%b want 1", rsp.q_ready); end
    req.q_valid = 1'b1; req.q.write = 1'b0; req.q.addr = 32'h6100;
    @(negedge clk_i); req.q_valid = 1'b0; #1;
    n_cmp++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.addr !== 32'h6100) begin n_bad++;
      $display("FAIL mid_rst_ar got v=%b a=%h want 1/00006100", axi_req.ar_valid, axi_req.ar.addr); end
    @(negedge clk_i); axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 32'h12345678;
    @(negedge clk_i); axi_rsp.r_valid = 1'b0; #1;
    n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'h12345678) begin n_bad++;
      $display("FAIL mid_rst_r got pv=%b d=%h want 1/12345678", rsp.p_valid, rsp.p.data); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_i = 1'b1; req = '0; axi_rsp = '0;
    test_reset();
    test_single_read();
    test_write_aw_delay();
    test_outstanding();
    test_back_to_back_order();
    test_errors();
    test_reset_mid();
    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
